// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the PWM datapath: immediate set, linear ramp or
// continuous breathing, with duty updates applied only on PWM period boundaries.
module pwm_fade_ctrl #(
   parameter int CBITS        = 18,
   parameter int DBITS        = 4,
   parameter int STEP_PERIODS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             period_tick,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [DBITS-1:0] cmd_target,
   output logic [DBITS-1:0] duty,
   output logic [CBITS-1:0] pulse_wide,
   output logic             busy,
   output logic             done
);

   localparam int SHIFT = CBITS - 1 - DBITS;
   localparam int SW    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);

   localparam logic [1:0] MODE_SET  = 2'd0;
   localparam logic [1:0] MODE_RAMP = 2'd1;
   localparam logic [1:0] MODE_OFF  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SET_PEND,
      RAMP,
      BR_UP,
      BR_DN
   } state_t;

   state_t           state;
   logic [DBITS-1:0] target;
   logic [SW-1:0]    step_cnt;
   logic             accept;
   logic             step_due;
   logic [DBITS-1:0] duty_up;
   logic [DBITS-1:0] duty_dn;

   assign cmd_ready  = (state == IDLE) || (state == BR_UP) || (state == BR_DN);
   assign busy       = (state != IDLE);
   assign accept     = cmd_valid & cmd_ready;
   assign step_due   = period_tick & (step_cnt == STEP_LAST);
   assign duty_up    = duty + DBITS'(1);
   assign duty_dn    = duty - DBITS'(1);
   assign pulse_wide = CBITS'(duty) << SHIFT;

   // Acceptance wins over a coincident period tick, so that tick never counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         duty     <= '0;
         target   <= '0;
         step_cnt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            step_cnt <= '0;
            case (cmd_mode)
               MODE_SET: begin
                  target <= cmd_target;
                  state  <= SET_PEND;
               end
               MODE_OFF: begin
                  target <= '0;
                  state  <= SET_PEND;
               end
               MODE_RAMP: begin
                  target <= cmd_target;
                  if (duty == cmd_target) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     state <= RAMP;
                  end
               end
               default: begin
                  if (cmd_target == '0) begin
                     target <= '0;
                     state  <= SET_PEND;
                  end else begin
                     target <= cmd_target;
                     state  <= (duty < cmd_target) ? BR_UP : BR_DN;
                  end
               end
            endcase
         end else if (period_tick) begin
            case (state)
               SET_PEND: begin
                  duty  <= target;
                  done  <= 1'b1;
                  state <= IDLE;
               end
               RAMP: begin
                  if (step_due) begin
                     step_cnt <= '0;
                     if (duty < target) begin
                        duty <= duty_up;
                        if (duty_up == target) begin
                           state <= IDLE;
                           done  <= 1'b1;
                        end
                     end else begin
                        duty <= duty_dn;
                        if (duty_dn == target) begin
                           state <= IDLE;
                           done  <= 1'b1;
                        end
                     end
                  end else begin
                     step_cnt <= step_cnt + SW'(1);
                  end
               end
               BR_UP: begin
                  if (step_due) begin
                     step_cnt <= '0;
                     duty     <= duty_up;
                     if (duty_up == target) state <= BR_DN;
                  end else begin
                     step_cnt <= step_cnt + SW'(1);
                  end
               end
               BR_DN: begin
                  if (step_due) begin
                     step_cnt <= '0;
                     duty     <= duty_dn;
                     if (duty_dn == '0) state <= BR_UP;
                  end else begin
                     step_cnt <= step_cnt + SW'(1);
                  end
               end
               default: begin
                  step_cnt <= step_cnt;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: set, ramp, breathe, preemption, tick
// coincidence and asynchronous reset, with period_tick every 8 clocks.
module tb_pwm_fade_ctrl;

   localparam int CBITS        = 18;
   localparam int DBITS        = 4;
   localparam int STEP_PERIODS = 4;

   localparam logic [1:0] M_SET     = 2'd0;
   localparam logic [1:0] M_RAMP    = 2'd1;
   localparam logic [1:0] M_BREATHE = 2'd2;
   localparam logic [1:0] M_OFF     = 2'd3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             period_tick;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_mode;
   logic [DBITS-1:0] cmd_target;
   logic [DBITS-1:0] duty;
   logic [CBITS-1:0] pulse_wide;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_fade_ctrl #(
      .CBITS(CBITS),
      .DBITS(DBITS),
      .STEP_PERIODS(STEP_PERIODS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .period_tick(period_tick),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode),
      .cmd_target(cmd_target),
      .duty(duty),
      .pulse_wide(pulse_wide),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic advance(input logic tick);
      period_tick = tick;
      @(posedge clk);
      #1;
      period_tick = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] tgt, input logic tick);
      cmd_valid  = 1'b1;
      cmd_mode   = mode;
      cmd_target = tgt;
      advance(tick);
      cmd_valid  = 1'b0;
   endtask

   task automatic runPeriod();
      repeat (7) advance(1'b0);
      advance(1'b1);
   endtask

   task automatic runStep();
      repeat (STEP_PERIODS) runPeriod();
   endtask

   initial begin
      logic [3:0] ramp_exp[3];
      logic [3:0] br_exp[6];
      logic [3:0] pre_exp[3];
      ramp_exp = '{4'd1, 4'd2, 4'd3};
      br_exp   = '{4'd1, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
      pre_exp  = '{4'd3, 4'd4, 4'd5};

      rst_n = 1'b0; period_tick = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_target = '0;
      repeat (3) advance(1'b0);
      checkOutput("rst duty", 32'(duty), 32'd0);
      checkOutput("rst pulse", 32'(pulse_wide), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      advance(1'b0);

      // SET 9: nothing changes until the first tick after acceptance
      applyStimulus(M_SET, 4'd9, 1'b0);
      checkOutput("set ready low", 32'(cmd_ready), 32'd0);
      checkOutput("set busy", 32'(busy), 32'd1);
      repeat (7) advance(1'b0);
      checkOutput("set duty held", 32'(duty), 32'd0);
      advance(1'b1);
      checkOutput("set duty", 32'(duty), 32'd9);
      checkOutput("set pulse", 32'(pulse_wide), 32'h12000);
      checkOutput("set done", 32'(done), 32'd1);
      advance(1'b0);
      checkOutput("set done clr", 32'(done), 32'd0);
      checkOutput("set ready back", 32'(cmd_ready), 32'd1);

      applyStimulus(M_OFF, 4'd6, 1'b0);
      runPeriod();
      checkOutput("off duty", 32'(duty), 32'd0);
      checkOutput("off done", 32'(done), 32'd1);
      advance(1'b0);

      // RAMP 0 -> 3, one LSB per 4 ticks
      applyStimulus(M_RAMP, 4'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         repeat (STEP_PERIODS - 1) runPeriod();
         checkOutput("ramp pre-step duty", 32'(duty), 32'(i));
         checkOutput("ramp ready", 32'(cmd_ready), 32'd0);
         runPeriod();
         checkOutput("ramp duty", 32'(duty), 32'(ramp_exp[i]));
         checkOutput("ramp done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      end
      advance(1'b0);
      checkOutput("ramp ready back", 32'(cmd_ready), 32'd1);
      checkOutput("ramp idle", 32'(busy), 32'd0);

      applyStimulus(M_OFF, 4'd0, 1'b0);
      runPeriod();
      advance(1'b0);
      checkOutput("off2 duty", 32'(duty), 32'd0);

      // BREATHE 2 from 0: 1,2,1,0,1,2 and never done
      applyStimulus(M_BREATHE, 4'd2, 1'b0);
      for (int i = 0; i < 6; i++) begin
         runStep();
         checkOutput("breathe duty", 32'(duty), 32'(br_exp[i]));
         checkOutput("breathe done", 32'(done), 32'd0);
         checkOutput("breathe ready", 32'(cmd_ready), 32'd1);
      end

      // Preempt while heading down from 2 with RAMP 5
      applyStimulus(M_RAMP, 4'd5, 1'b0);
      checkOutput("preempt ready low", 32'(cmd_ready), 32'd0);
      checkOutput("preempt duty hold", 32'(duty), 32'd2);
      for (int i = 0; i < 3; i++) begin
         runStep();
         checkOutput("preempt duty", 32'(duty), 32'(pre_exp[i]));
         checkOutput("preempt done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      end
      advance(1'b0);

      applyStimulus(M_SET, 4'd7, 1'b0);
      runPeriod();
      advance(1'b0);
      checkOutput("set7 duty", 32'(duty), 32'd7);

      // RAMP to the current duty completes without any tick
      applyStimulus(M_RAMP, 4'd7, 1'b0);
      checkOutput("ramp eq done", 32'(done), 32'd1);
      checkOutput("ramp eq duty", 32'(duty), 32'd7);
      advance(1'b0);
      checkOutput("ramp eq done clr", 32'(done), 32'd0);

      // A tick in the acceptance cycle must not apply the SET
      applyStimulus(M_SET, 4'd3, 1'b1);
      checkOutput("coinc duty", 32'(duty), 32'd7);
      checkOutput("coinc done", 32'(done), 32'd0);
      checkOutput("coinc pending", 32'(cmd_ready), 32'd0);
      runPeriod();
      checkOutput("coinc applied", 32'(duty), 32'd3);
      checkOutput("coinc applied done", 32'(done), 32'd1);
      advance(1'b0);

      // Asynchronous reset mid-ramp, between clock edges
      applyStimulus(M_RAMP, 4'd10, 1'b0);
      runStep();
      checkOutput("ramp10 duty", 32'(duty), 32'd4);
      runPeriod();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async duty", 32'(duty), 32'd0);
      checkOutput("async done", 32'(done), 32'd0);
      checkOutput("async busy", 32'(busy), 32'd0);
      checkOutput("async ready", 32'(cmd_ready), 32'd1);
      checkOutput("async pulse", 32'(pulse_wide), 32'd0);
      advance(1'b0);
      rst_n = 1'b1;
      advance(1'b0);
      checkOutput("post rst busy", 32'(busy), 32'd0);

      applyStimulus(M_SET, 4'd5, 1'b0);
      runPeriod();
      checkOutput("resume duty", 32'(duty), 32'd5);
      checkOutput("resume pulse", 32'(pulse_wide), 32'h0A000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
      $finish;
   end

endmodule
